// File: rtl/apb_master_arbiter_if.sv
// APB bus bundle between the multi-requester master and its peripherals.
// The master modport drives the request side; the slave modport returns data and handshake.
interface apb_master_arbiter_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int STRB_WIDTH  = DATA_WIDTH / 8,
  parameter int PERIPHERALS = 4
);
  logic [ADDR_WIDTH-1:0]  paddr;
  logic [PERIPHERALS-1:0] pselx;
  logic                   penable;
  logic                   pwrite;
  logic [DATA_WIDTH-1:0]  pwdata;
  logic [STRB_WIDTH-1:0]  pstrb;
  logic [DATA_WIDTH-1:0]  prdata;
  logic                   pready;
  logic                   pslverr;

  modport master (
    output paddr, pselx, penable, pwrite, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, pselx, penable, pwrite, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// Round-robin APB master: serves single-beat commands from NUM_REQ requesters,
// decodes 4 KB peripheral windows, sequences SETUP/ACCESS and bounds stalls with a timeout.
module apb_master_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int STRB_WIDTH  = DATA_WIDTH / 8,
  parameter int PERIPHERALS = 4,
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT     = 16
) (
  input  logic                         pclk,
  input  logic                         preset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ-1:0]           req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_REQ*STRB_WIDTH-1:0] req_strb,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [DATA_WIDTH-1:0]        rsp_rdata,
  output logic                         rsp_err,
  apb_master_arbiter_if.master         apb
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int IDX_W = (PERIPHERALS > 1) ? $clog2(PERIPHERALS) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e                 state_q,   state_d;
  logic [PTR_W-1:0]       rr_ptr_q,  rr_ptr_d;
  logic [PTR_W-1:0]       owner_q,   owner_d;
  logic [CNT_W-1:0]       cnt_q,     cnt_d;
  logic [ADDR_WIDTH-1:0]  paddr_q,   paddr_d;
  logic [PERIPHERALS-1:0] psel_q,    psel_d;
  logic                   penable_q, penable_d;
  logic                   pwrite_q,  pwrite_d;
  logic [DATA_WIDTH-1:0]  pwdata_q,  pwdata_d;
  logic [STRB_WIDTH-1:0]  pstrb_q,   pstrb_d;
  logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic                   rsp_err_q,   rsp_err_d;

  logic                   grant_found;
  logic [PTR_W-1:0]       grant_idx;
  logic [ADDR_WIDTH-1:0]  g_addr;
  logic                   g_write;
  logic [DATA_WIDTH-1:0]  g_wdata;
  logic [STRB_WIDTH-1:0]  g_strb;
  logic [IDX_W-1:0]       g_idx;
  logic                   dec_err;

  // Search starts at rr_ptr and wraps, so the last-served requester has lowest priority.
  always_comb begin
    int cand;
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = PTR_W'(cand);
      end
    end
  end

  always_comb begin
    g_addr  = req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
    g_write = req_write[grant_idx];
    g_wdata = req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    g_strb  = req_strb[grant_idx*STRB_WIDTH +: STRB_WIDTH];
    g_idx   = (PERIPHERALS > 1) ? g_addr[12 +: IDX_W] : '0;
    dec_err = (int'(g_idx) >= PERIPHERALS);
  end

  assign req_ready = (state_q == IDLE && grant_found && !preset)
                     ? (NUM_REQ'(1) << grant_idx) : '0;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    paddr_d     = paddr_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          owner_d  = grant_idx;
          rr_ptr_d = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          if (dec_err) begin
            // Unmapped window: answer immediately without touching the bus.
            rsp_valid_d = NUM_REQ'(1) << grant_idx;
            rsp_err_d   = 1'b1;
          end else begin
            state_d   = SETUP;
            paddr_d   = g_addr;
            pwrite_d  = g_write;
            pwdata_d  = g_write ? g_wdata : '0;
            pstrb_d   = g_write ? g_strb  : '0;
            psel_d    = PERIPHERALS'(1) << g_idx;
            penable_d = 1'b0;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        cnt_d     = CNT_W'(1);
      end
      ACCESS: begin
        if (apb.pready) begin
          rsp_valid_d = NUM_REQ'(1) << owner_q;
          rsp_rdata_d = (!pwrite_q && !apb.pslverr) ? apb.prdata : '0;
          rsp_err_d   = apb.pslverr;
          psel_d      = '0;
          penable_d   = 1'b0;
          cnt_d       = '0;
          state_d     = IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          rsp_valid_d = NUM_REQ'(1) << owner_q;
          rsp_err_d   = 1'b1;
          psel_d      = '0;
          penable_d   = 1'b0;
          cnt_d       = '0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      paddr_q     <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      paddr_q     <= paddr_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign apb.paddr   = paddr_q;
  assign apb.pselx   = psel_q;
  assign apb.penable = penable_q;
  assign apb.pwrite  = pwrite_q;
  assign apb.pwdata  = pwdata_q;
  assign apb.pstrb   = pstrb_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter: per-cycle vector table plus hand sequences
// for timeout, reset mid-transfer and decode error on a 3-peripheral instance.
module tb_apb_master_arbiter;

  logic        pclk = 1'b0;
  logic        preset;
  logic [1:0]  req_valid, req_ready, req_write, rsp_valid;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_strb;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic [1:0]  req_valid3, req_ready3, req_write3, rsp_valid3;
  logic [63:0] req_addr3, req_wdata3;
  logic [7:0]  req_strb3;
  logic [31:0] rsp_rdata3;
  logic        rsp_err3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 pclk = ~pclk;

  apb_master_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PERIPHERALS(4)) bus ();
  apb_master_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PERIPHERALS(3)) bus3 ();

  apb_master_arbiter #(.PERIPHERALS(4), .NUM_REQ(2), .TIMEOUT(16)) dut (
    .pclk(pclk), .preset(preset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .apb(bus.master)
  );

  apb_master_arbiter #(.PERIPHERALS(3), .NUM_REQ(2), .TIMEOUT(16)) dut3 (
    .pclk(pclk), .preset(preset),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_write(req_write3),
    .req_addr(req_addr3), .req_wdata(req_wdata3), .req_strb(req_strb3),
    .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3),
    .apb(bus3.master)
  );

  typedef struct packed {
    logic [1:0]  rdy;
    logic [3:0]  sel;
    logic        en;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  rv;
    logic [31:0] rdata;
    logic        err;
  } outs_t;

  typedef struct packed {
    logic [1:0]  v;
    logic [1:0]  w;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] wd;
    logic [3:0]  sb;
    logic        prdy;
    logic        slv;
    logic [31:0] prd;
  } ins_t;

  typedef struct packed {
    ins_t  in;
    outs_t exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic ins_t I(logic [1:0] v, logic [1:0] w, logic [31:0] a0, logic [31:0] a1,
                             logic [31:0] wd, logic [3:0] sb, logic prdy, logic slv, logic [31:0] prd);
    I = '{v, w, a0, a1, wd, sb, prdy, slv, prd};
  endfunction

  function automatic outs_t O(logic [1:0] rdy, logic [3:0] sel, logic en, logic wr,
                              logic [31:0] addr, logic [31:0] wdata, logic [3:0] strb,
                              logic [1:0] rv, logic [31:0] rdata, logic err);
    O = '{rdy, sel, en, wr, addr, wdata, strb, rv, rdata, err};
  endfunction

  function automatic outs_t sample();
    sample = {req_ready, bus.pselx, bus.penable, bus.pwrite, bus.paddr, bus.pwdata,
              bus.pstrb, rsp_valid, rsp_rdata, rsp_err};
  endfunction

  task automatic drive(ins_t x);
    req_valid   = x.v;
    req_write   = x.w;
    req_addr    = {x.a1, x.a0};
    req_wdata   = {x.wd, x.wd};
    req_strb    = {x.sb, x.sb};
    bus.pready  = x.prdy;
    bus.pslverr = x.slv;
    bus.prdata  = x.prd;
  endtask

  task automatic drive3(logic [1:0] v, logic [1:0] w, logic [31:0] a0, logic prdy);
    req_valid3   = v;
    req_write3   = w;
    req_addr3    = {32'h0, a0};
    req_wdata3   = 64'h0;
    req_strb3    = 8'h0;
    bus3.pready  = prdy;
    bus3.pslverr = 1'b0;
    bus3.prdata  = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not terminate in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   acc;
    logic done;
    localparam logic [31:0] DB = 32'hDEADBEEF;
    localparam logic [31:0] CW = 32'h11112222;
    localparam logic [31:0] CF = 32'hCAFEF00D;

    // Zero-wait write, then read with 3 wait states (pstrb forced to 0 on reads).
    vecs.push_back('{I(2'b01, 2'b01, 32'h1004, 0, DB, 4'hF, 0, 0, 0), O(2'b01, 4'b0000, 0, 0, 0, 0, 0, 2'b00, 0, 0)});
    vecs.push_back('{I(2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0),             O(2'b00, 4'b0010, 0, 1, 32'h1004, DB, 4'hF, 2'b00, 0, 0)});
    vecs.push_back('{I(2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 32'hAAAA5555), O(2'b00, 4'b0010, 1, 1, 32'h1004, DB, 4'hF, 2'b00, 0, 0)});
    vecs.push_back('{I(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0),             O(2'b00, 4'b0000, 0, 1, 32'h1004, DB, 4'hF, 2'b01, 0, 0)});
    vecs.push_back('{I(2'b10, 2'b00, 0, 32'h3000, 0, 4'hF, 0, 0, 0),   O(2'b10, 4'b0000, 0, 1, 32'h1004, DB, 4'hF, 2'b00, 0, 0)});
    vecs.push_back('{I(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0),             O(2'b00, 4'b1000, 0, 0, 32'h3000, 0, 0, 2'b00, 0, 0)});
    vecs.push_back('{I(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0),             O(2'b00, 4'b1000, 1, 0, 32'h3000, 0, 0, 2'b00, 0, 0)});
    vecs.push_back('{I(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0),             O(2'b00, 4'b1000, 1, 0, 32'h3000, 0, 0, 2'b00, 0, 0)});
    vecs.push_back('{I(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0),             O(2'b00, 4'b1000, 1, 0, 32'h3000, 0, 0, 2'b00, 0, 0)});
    vecs.push_back('{I(2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 32'h12345678), O(2'b00, 4'b1000, 1, 0, 32'h3000, 0, 0, 2'b00, 0, 0)});
    vecs.push_back('{I(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0),             O(2'b00, 4'b0000, 0, 0, 32'h3000, 0, 0, 2'b10, 32'h12345678, 0)});
    // Contention: both requesters hold valid; grants alternate 0,1,0,1 back-to-back.
    vecs.push_back('{I(2'b11, 2'b11, 0, 32'h2008, CW, 4'h3, 0, 0, 0), O(2'b01, 4'b0000, 0, 0, 32'h3000, 0, 0, 2'b00, 0, 0)});
    vecs.push_back('{I(2'b11, 2'b11, 0, 32'h2008, CW, 4'h3, 0, 0, 0), O(2'b00, 4'b0001, 0, 1, 32'h0000, CW, 4'h3, 2'b00, 0, 0)});
    vecs.push_back('{I(2'b11, 2'b11, 0, 32'h2008, CW, 4'h3, 1, 0, 0), O(2'b00, 4'b0001, 1, 1, 32'h0000, CW, 4'h3, 2'b00, 0, 0)});
    vecs.push_back('{I(2'b11, 2'b11, 0, 32'h2008, CW, 4'h3, 0, 0, 0), O(2'b10, 4'b0000, 0, 1, 32'h0000, CW, 4'h3, 2'b01, 0, 0)});
    vecs.push_back('{I(2'b11, 2'b11, 0, 32'h2008, CW, 4'h3, 0, 0, 0), O(2'b00, 4'b0100, 0, 1, 32'h2008, CW, 4'h3, 2'b00, 0, 0)});
    vecs.push_back('{I(2'b11, 2'b11, 0, 32'h2008, CW, 4'h3, 1, 0, 0), O(2'b00, 4'b0100, 1, 1, 32'h2008, CW, 4'h3, 2'b00, 0, 0)});
    vecs.push_back('{I(2'b11, 2'b11, 0, 32'h2008, CW, 4'h3, 0, 0, 0), O(2'b01, 4'b0000, 0, 1, 32'h2008, CW, 4'h3, 2'b10, 0, 0)});
    vecs.push_back('{I(2'b11, 2'b11, 0, 32'h2008, CW, 4'h3, 0, 0, 0), O(2'b00, 4'b0001, 0, 1, 32'h0000, CW, 4'h3, 2'b00, 0, 0)});
    vecs.push_back('{I(2'b11, 2'b11, 0, 32'h2008, CW, 4'h3, 1, 0, 0), O(2'b00, 4'b0001, 1, 1, 32'h0000, CW, 4'h3, 2'b00, 0, 0)});
    vecs.push_back('{I(2'b10, 2'b11, 0, 32'h2008, CW, 4'h3, 0, 0, 0), O(2'b10, 4'b0000, 0, 1, 32'h0000, CW, 4'h3, 2'b01, 0, 0)});
    vecs.push_back('{I(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0),             O(2'b00, 4'b0100, 0, 1, 32'h2008, CW, 4'h3, 2'b00, 0, 0)});
    vecs.push_back('{I(2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0),             O(2'b00, 4'b0100, 1, 1, 32'h2008, CW, 4'h3, 2'b00, 0, 0)});
    vecs.push_back('{I(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0),             O(2'b00, 4'b0000, 0, 1, 32'h2008, CW, 4'h3, 2'b10, 0, 0)});
    // Slave error on a write with one wait state; pslverr without pready is ignored.
    vecs.push_back('{I(2'b01, 2'b01, 32'h1000, 0, CF, 4'h5, 0, 0, 0), O(2'b01, 4'b0000, 0, 1, 32'h2008, CW, 4'h3, 2'b00, 0, 0)});
    vecs.push_back('{I(2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0),             O(2'b00, 4'b0010, 0, 1, 32'h1000, CF, 4'h5, 2'b00, 0, 0)});
    vecs.push_back('{I(2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0),             O(2'b00, 4'b0010, 1, 1, 32'h1000, CF, 4'h5, 2'b00, 0, 0)});
    vecs.push_back('{I(2'b00, 2'b00, 0, 0, 0, 0, 1, 1, 32'hFFFFFFFF), O(2'b00, 4'b0010, 1, 1, 32'h1000, CF, 4'h5, 2'b00, 0, 0)});
    vecs.push_back('{I(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0),             O(2'b00, 4'b0000, 0, 1, 32'h1000, CF, 4'h5, 2'b01, 0, 1)});

    // Reset with requests pending: req_ready must stay low and all outputs clear.
    preset = 1'b1;
    drive(I(2'b11, 2'b11, 32'h1000, 32'h2000, 0, 0, 0, 0, 0));
    drive3(2'b00, 2'b00, 0, 1'b0);
    repeat (2) @(negedge pclk);
    #1;
    check("reset_outputs", sample(), '0);
    check("reset_outputs_p3", {req_ready3, bus3.pselx, bus3.penable, rsp_valid3, rsp_err3}, '0);

    foreach (vecs[i]) begin
      @(negedge pclk);
      preset = 1'b0;
      drive(vecs[i].in);
      #1;
      check($sformatf("vec%0d", i), sample(), vecs[i].exp);
    end

    // Timeout: requester 1 reads with pready stuck low.
    @(negedge pclk);
    drive(I(2'b10, 2'b00, 0, 32'h2000, 0, 4'hF, 0, 0, 0));
    #1;
    check("timeout_grant", req_ready, 2'b10);
    @(negedge pclk);
    drive(I(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 32'h55555555));
    #1;
    check("timeout_setup", {bus.pselx, bus.penable}, {4'b0100, 1'b0});
    acc  = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge pclk);
      #1;
      if (bus.penable) acc++;
      else begin
        done = 1'b1;
        check("timeout_rsp", {bus.pselx, rsp_valid, rsp_err, rsp_rdata}, {4'b0000, 2'b10, 1'b1, 32'h0});
      end
    end
    check("timeout_done", done, 1);
    check("timeout_access_cycles", acc, 16);

    // Next request is served normally.
    @(negedge pclk);
    drive(I(2'b01, 2'b00, 32'h0004, 0, 0, 0, 0, 0, 0));
    #1;
    check("post_to_grant", req_ready, 2'b01);
    @(negedge pclk);
    drive(I(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    #1;
    check("post_to_setup", {bus.pselx, bus.penable, bus.pwrite}, {4'b0001, 1'b0, 1'b0});
    @(negedge pclk);
    drive(I(2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 32'h0BADF00D));
    @(negedge pclk);
    drive(I(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    #1;
    check("post_to_rsp", {rsp_valid, rsp_err, rsp_rdata}, {2'b01, 1'b0, 32'h0BADF00D});

    // Reset during a wait-stated read: transfer dropped, rr_ptr back to requester 0.
    @(negedge pclk);
    drive(I(2'b01, 2'b00, 32'h3000, 0, 0, 0, 0, 0, 0));
    #1;
    check("rst_grant", req_ready, 2'b01);
    @(negedge pclk);
    drive(I(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(negedge pclk);
    #1;
    check("rst_in_access", {bus.pselx, bus.penable}, {4'b1000, 1'b1});
    @(negedge pclk);
    preset = 1'b1;
    drive(I(2'b11, 2'b00, 0, 32'h1000, 0, 0, 0, 0, 0));
    @(negedge pclk);
    #1;
    check("rst_abort", sample(), '0);
    preset = 1'b0;
    #1;
    check("rst_rr_ptr", req_ready, 2'b01);
    @(negedge pclk);
    drive(I(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    #1;
    check("rst_no_rsp", {rsp_valid, bus.pselx}, {2'b00, 4'b0001});
    @(negedge pclk);
    drive(I(2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 32'h00C0FFEE));
    @(negedge pclk);
    drive(I(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    #1;
    check("rst_after_rsp", {rsp_valid, rsp_rdata}, {2'b01, 32'h00C0FFEE});

    // Decode error on the 3-peripheral instance, then a valid access there.
    @(negedge pclk);
    drive3(2'b01, 2'b01, 32'h3000, 1'b0);
    #1;
    check("dec_grant", {req_ready3, bus3.pselx}, {2'b01, 3'b000});
    @(negedge pclk);
    drive3(2'b00, 2'b00, 0, 1'b0);
    #1;
    check("dec_rsp", {rsp_valid3, rsp_err3, rsp_rdata3, bus3.pselx, bus3.penable},
          {2'b01, 1'b1, 32'h0, 3'b000, 1'b0});
    @(negedge pclk);
    #1;
    check("dec_idle", {rsp_valid3, bus3.pselx, bus3.penable}, {2'b00, 3'b000, 1'b0});
    drive3(2'b01, 2'b00, 32'h2000, 1'b0);
    #1;
    check("dec_valid_grant", req_ready3, 2'b01);
    @(negedge pclk);
    drive3(2'b00, 2'b00, 0, 1'b0);
    #1;
    check("dec_valid_setup", {bus3.pselx, bus3.penable}, {3'b100, 1'b0});
    @(negedge pclk);
    drive3(2'b00, 2'b00, 0, 1'b1);
    @(negedge pclk);
    drive3(2'b00, 2'b00, 0, 1'b0);
    #1;
    check("dec_valid_rsp", {rsp_valid3, rsp_err3}, {2'b01, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Multi-requester APB master: accepts single-beat read/write commands from NUM_REQ internal requesters, arbitrates round-robin, decodes the target peripheral from the address, and sequences the APB SETUP/ACCESS phases on the shared bus. It sits between the system-side request ports and the APB bus feeding the peripherals/responders. It returns read data and error status to the granted requester, and it bounds stalled transfers with a timeout.

## Interface
- ADDR_WIDTH, 32, APB address width
- DATA_WIDTH, 32, APB data width (8/16/32)
- STRB_WIDTH, DATA_WIDTH/8, byte-strobe width
- PERIPHERALS, 4, number of pselx lines (1..16)
- NUM_REQ, 2, number of requesters (2..8)
- TIMEOUT, 16, max ACCESS cycles waiting for pready (>=2)

Ports:
- pclk  in  1  bus clock; everything is on posedge
- preset  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high)
- req_valid  in  NUM_REQ  per-requester command valid
- req_ready  out  NUM_REQ  one-hot accept pulse (combinational)
- req_write  in  NUM_REQ  1=write, 0=read
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
- req_strb  in  NUM_REQ*STRB_WIDTH  packed byte strobes
- rsp_valid  out  NUM_REQ  one-hot, one-cycle response pulse to the owning requester
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid (0 for writes/errors)
- rsp_err  out  1  error flag, valid with rsp_valid
- paddr  out  ADDR_WIDTH
- pselx  out  PERIPHERALS  one-hot select
- penable  out  1
- pwrite  out  1
- pwdata  out  DATA_WIDTH
- pstrb  out  STRB_WIDTH
- prdata  in  DATA_WIDTH
- pready  in  1
- pslverr  in  1

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - If any req_valid is set, grant the first set requester at or after rr_ptr, wrapping.
  - Assert req_ready[g] in the same cycle and latch that requester's command at the edge.
  - Set rr_ptr = (g+1) mod NUM_REQ.
- Decode: idx = paddr[12 +: $clog2(PERIPHERALS)], so each peripheral owns a 4 KB window.
  - idx >= PERIPHERALS is a decode error. No bus cycle is issued, and the next cycle returns rsp_err=1 with rdata=0. The FSM stays in IDLE.
- SETUP: drive paddr, pwrite, and pselx[idx]=1 with penable=0.
  - Writes drive pwdata/pstrb from the command.
  - Reads drive pwdata=0 and pstrb=0 regardless of req_strb.
  - Always go to ACCESS.
- ACCESS: penable=1 and all other bus signals are held stable.
  - pready=1 at an edge: capture prdata (reads only, else 0) and pslverr. Pulse rsp_valid[g] the next cycle. Drop pselx/penable to 0 and return to IDLE.
  - A cycle counter starts at 1 on entry. If it reaches TIMEOUT with pready still 0, abort: drop pselx/penable, respond rsp_err=1 with rdata=0, and return to IDLE.
- The IDLE cycle that carries rsp_valid may grant a new request, so back-to-back transfers are allowed.
- No idle bus cycle is inserted beyond IDLE itself.
- Only one transfer is outstanding at a time. Ungranted requesters hold req_valid and their command stable until req_ready.

## Timing
- Reset values (registered at the first preset edge):
  - Outputs: paddr, pwdata, pstrb, pselx, penable, pwrite, rsp_valid, rsp_rdata, rsp_err = 0.
  - req_ready is forced to 0 while preset=1.
  - FSM returns to IDLE, rr_ptr=0, timeout counter=0.
- Reset during SETUP/ACCESS aborts the transfer with no response issued. The bus returns to idle on the next edge.
- Minimum transfer time: grant edge, then 1 SETUP cycle, then 1 ACCESS cycle, with rsp_valid in the following cycle.
  - Zero-wait latency is 3 cycles from grant to rsp_valid.
  - Each wait state adds 1 cycle.
- pready/pslverr/prdata are sampled only in ACCESS and ignored otherwise.
- pslverr is reported only for completed transfers. Timeout and decode errors both set rsp_err.
- A requester that drops req_valid before req_ready is simply not served. It is not an error.

## Test plan
- Single write, zero wait: requester 0 writes addr 0x0000_1004, data 0xDEADBEEF, strb 0xF -> pselx=0b0010 for one SETUP cycle then one ACCESS cycle; rsp_valid[0] 3 cycles after grant with rsp_err=0.
- Read with 3 wait states: requester 1 reads 0x0000_3000, pready low for 3 ACCESS cycles, prdata=0x12345678 -> pselx=0b1000, pstrb=0 throughout, rsp_rdata=0x12345678 six cycles after grant.
- Contention: both requesters hold req_valid for four transfers -> grants alternate 0,1,0,1 starting from requester 0 after reset; no idle cycles between transfers beyond IDLE.
- Timeout: pready held 0 with TIMEOUT=16 -> exactly 16 ACCESS cycles, then bus idle, rsp_err=1, rsp_rdata=0; the next request is served normally.
- Decode error and slave error:
  - PERIPHERALS=3 and address 0x0000_3000 -> no pselx asserted, rsp_err=1 the cycle after grant.
  - pslverr=1 with pready=1 on a valid access -> rsp_err=1.
- Reset in ACCESS: assert preset during a wait-stated read -> all outputs 0 on the next edge, no rsp_valid, rr_ptr=0, so the next arbitration favours requester 0.
